// File: rtl/branch_history_table.sv
// branch_history_table: direct-mapped table of 2-bit saturating branch
// counters with a one-entry pending-write register, a registered
// mispredict/redirect output and saturating branch statistics.
module branch_history_table #(
  parameter int          IDX_BITS = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic [1:0]  predictionbuffer,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_predicted,
  input  logic [31:0] upd_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Counter step: taken moves toward strong-taken, not-taken toward
  // strong-not-taken, both saturating at the ends.
  function automatic logic [1:0] next_cnt(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken) begin
      if (c != 2'b11) r = c + 2'd1;
    end else begin
      if (c != 2'b00) r = c - 2'd1;
    end
    return r;
  endfunction

  logic [IDX_BITS-1:0]          rd_idx;
  logic [IDX_BITS-1:0]          upd_idx;
  logic [ENTRIES-1:0][1:0]      table_q;

  logic                         pend_valid_reg;
  logic [IDX_BITS-1:0]          pend_idx_reg;
  logic [1:0]                   pend_val_reg;

  logic [1:0]                   upd_cur;
  logic [1:0]                   upd_new;
  logic                         upd_mispredict;

  // PC bits outside the index field are deliberately ignored (no tag).
  logic                         unused_rd_bits;

  assign rd_idx         = rd_pc[IDX_BITS+1:2];
  assign upd_idx        = upd_pc[IDX_BITS+1:2];
  assign unused_rd_bits = ^{rd_pc[31:IDX_BITS+2], rd_pc[1:0]};

  // Table storage: one register per entry so the whole table resets to
  // CNT_INIT; an entry is only written by the retiring pending write.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [1:0] cnt_reg;

      // Retire the pending write into this entry when it targets it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= CNT_INIT;
        end else if (pend_valid_reg && (pend_idx_reg == IDX_BITS'(gi))) begin
          cnt_reg <= pend_val_reg;
        end
      end

      assign table_q[gi] = cnt_reg;
    end
  endgenerate

  // Current counter for the incoming update: forward the pending value when
  // it targets the same entry so back-to-back updates chain correctly.
  always_comb begin
    upd_cur = table_q[upd_idx];
    if (pend_valid_reg && (pend_idx_reg == upd_idx)) begin
      upd_cur = pend_val_reg;
    end
    upd_new        = next_cnt(upd_cur, upd_taken);
    upd_mispredict = upd_valid && (upd_taken != upd_predicted);
  end

  // Fetch-side read with the pending write bypassed; depends only on rd_pc
  // and registered state, never on the update inputs.
  always_comb begin
    predictionbuffer = table_q[rd_idx];
    if (pend_valid_reg && (pend_idx_reg == rd_idx)) begin
      predictionbuffer = pend_val_reg;
    end
  end

  // Pending-write register: captures every accepted update for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_reg <= 1'b0;
      pend_idx_reg   <= '0;
      pend_val_reg   <= CNT_INIT;
    end else begin
      pend_valid_reg <= upd_valid;
      if (upd_valid) begin
        pend_idx_reg <= upd_idx;
        pend_val_reg <= upd_new;
      end
    end
  end

  // Mispredict pulse and correct next PC; redirect holds between updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= 32'h0000_0000;
    end else begin
      mispredict <= upd_mispredict;
      if (upd_valid) begin
        redirect_pc <= upd_taken ? upd_target : (upd_pc + 32'd4);
      end
    end
  end

  // Saturating statistics counters; they stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= 16'h0000;
      mispredict_count <= 16'h0000;
    end else begin
      if (upd_valid && (branch_count != 16'hFFFF)) begin
        branch_count <= branch_count + 16'd1;
      end
      if (upd_mispredict && (mispredict_count != 16'hFFFF)) begin
        mispredict_count <= mispredict_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Testbench for branch_history_table: reset sweep, directed vector table,
// asynchronous reset during a pending write, randomized run against a
// behavioural model, and statistics saturation.
module tb_branch_history_table;

  logic        clk;
  logic        rst;
  logic [31:0] rd_pc;
  logic [1:0]  predictionbuffer;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_predicted;
  logic [31:0] upd_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int checks;
  int errors;

  branch_history_table dut (
    .clk              (clk),
    .rst              (rst),
    .rd_pc            (rd_pc),
    .predictionbuffer (predictionbuffer),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_predicted    (upd_predicted),
    .upd_target       (upd_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        t;
    logic        p;
    logic [31:0] tgt;
    logic [31:0] rd;
    logic [1:0]  exp_pb;
    logic        exp_mis;
    logic [31:0] exp_red;
    logic [15:0] exp_bc;
    logic [15:0] exp_mc;
  } vec_t;

  vec_t vecs [13];

  // Behavioural model: counters are updated immediately on acceptance,
  // which is what a correct bypass/forwarding path makes visible.
  int unsigned m_tbl [64];
  logic        m_mis;
  logic [31:0] m_red;
  int unsigned m_bc;
  int unsigned m_mc;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) & 32'd63;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 1;
    m_mis = 1'b0;
    m_red = 32'h0;
    m_bc  = 0;
    m_mc  = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] pc, input logic t,
                            input logic p, input logic [31:0] tgt);
    int unsigned k;
    m_mis = v && (t != p);
    if (v) begin
      k = idx_of(pc);
      if (t && m_tbl[k] < 3) m_tbl[k] = m_tbl[k] + 1;
      if (!t && m_tbl[k] > 0) m_tbl[k] = m_tbl[k] - 1;
      m_red = t ? tgt : pc + 32'd4;
      if (m_bc < 65535) m_bc = m_bc + 1;
      if (m_mis && m_mc < 65535) m_mc = m_mc + 1;
    end
  endtask

  task automatic do_reset();
    upd_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rd_pc = 32'h0;
    upd_valid = 1'b0;
    upd_pc = 32'h0;
    upd_taken = 1'b0;
    upd_predicted = 1'b0;
    upd_target = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: every entry weakly not-taken, outputs cleared.
    for (int a = 0; a <= 32'hFC; a += 4) begin
      rd_pc = a;
      #1;
      check($sformatf("reset_pb_%02h", a), 32'(predictionbuffer), 32'h1);
    end
    check("reset_mispredict", 32'(mispredict), 32'h0);
    check("reset_redirect", redirect_pc, 32'h0);
    check("reset_branch_count", 32'(branch_count), 32'h0);
    check("reset_mispredict_count", 32'(mispredict_count), 32'h0);
    $display("reset sweep done");

    // No same-cycle path from update inputs to the prediction read.
    @(negedge clk);
    rd_pc = 32'h84; upd_valid = 1'b1; upd_pc = 32'h84; upd_taken = 1'b1;
    #1 check("no_comb_upd_path", 32'(predictionbuffer), 32'h1);
    upd_valid = 1'b0;
    $display("comb isolation: pb=%0d", predictionbuffer);

    vecs[0]  = '{1'b1, 32'h40,       1'b1, 1'b0, 32'h100,  32'h40,       2'd2, 1'b1, 32'h100,  16'd1,  16'd1};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h140,      2'd2, 1'b0, 32'h100,  16'd1,  16'd1};
    vecs[2]  = '{1'b1, 32'h40,       1'b1, 1'b1, 32'h200,  32'h40,       2'd3, 1'b0, 32'h200,  16'd2,  16'd1};
    vecs[3]  = '{1'b1, 32'h40,       1'b1, 1'b1, 32'h204,  32'h40,       2'd3, 1'b0, 32'h204,  16'd3,  16'd1};
    vecs[4]  = '{1'b1, 32'h40,       1'b0, 1'b1, 32'h300,  32'h40,       2'd2, 1'b1, 32'h44,   16'd4,  16'd2};
    vecs[5]  = '{1'b1, 32'h40,       1'b0, 1'b0, 32'h300,  32'h40,       2'd1, 1'b0, 32'h44,   16'd5,  16'd2};
    vecs[6]  = '{1'b1, 32'h40,       1'b0, 1'b0, 32'h300,  32'h40,       2'd0, 1'b0, 32'h44,   16'd6,  16'd2};
    vecs[7]  = '{1'b1, 32'h40,       1'b0, 1'b0, 32'h300,  32'h40,       2'd0, 1'b0, 32'h44,   16'd7,  16'd2};
    vecs[8]  = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 32'h500,  32'hFFFFFFFC, 2'd0, 1'b1, 32'h0,    16'd8,  16'd3};
    vecs[9]  = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h500,  32'h40,       2'd0, 1'b0, 32'h0,    16'd9,  16'd3};
    vecs[10] = '{1'b1, 32'h80,       1'b1, 1'b0, 32'h1234, 32'h44,       2'd1, 1'b1, 32'h1234, 16'd10, 16'd4};
    vecs[11] = '{1'b0, 32'h80,       1'b1, 1'b0, 32'h9999, 32'h80,       2'd2, 1'b0, 32'h1234, 16'd10, 16'd4};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'hFFFFFFFC, 2'd0, 1'b0, 32'h1234, 16'd10, 16'd4};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      upd_valid = vecs[i].v; upd_pc = vecs[i].pc; upd_taken = vecs[i].t;
      upd_predicted = vecs[i].p; upd_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      rd_pc = vecs[i].rd;
      #1;
      check($sformatf("vec%0d_pb", i), 32'(predictionbuffer), 32'(vecs[i].exp_pb));
      check($sformatf("vec%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].exp_mis));
      check($sformatf("vec%0d_redirect", i), redirect_pc, vecs[i].exp_red);
      check($sformatf("vec%0d_branch_count", i), 32'(branch_count), 32'(vecs[i].exp_bc));
      check($sformatf("vec%0d_mispredict_count", i), 32'(mispredict_count), 32'(vecs[i].exp_mc));
      $display("vec%0d: upd_v=%0b pc=%08h t=%0b p=%0b rd=%08h pb=%0d mis=%0b red=%08h bc=%0d mc=%0d",
               i, vecs[i].v, vecs[i].pc, vecs[i].t, vecs[i].p, rd_pc, predictionbuffer,
               mispredict, redirect_pc, branch_count, mispredict_count);
    end

    // Asynchronous reset while a write to 0x48 is still pending.
    do_reset();
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h48; upd_taken = 1'b1; upd_predicted = 1'b1;
    @(posedge clk);
    #1 upd_valid = 1'b0;
    rd_pc = 32'h48;
    #1 check("midrst_bypass_before", 32'(predictionbuffer), 32'h2);
    rst = 1'b1;
    #1 check("midrst_async_pb", 32'(predictionbuffer), 32'h1);
    check("midrst_async_bc", 32'(branch_count), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("midrst_after_pb", 32'(predictionbuffer), 32'h1);
    check("midrst_after_redirect", redirect_pc, 32'h0);
    $display("mid-op reset: pb=%0d bc=%0d", predictionbuffer, branch_count);

    // Randomized run against the behavioural model.
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic v, t, p;
      logic [31:0] pc, tgt, rp;
      r   = $urandom();
      v   = ($urandom_range(0, 3) != 0);
      t   = $urandom_range(0, 1) == 1;
      p   = $urandom_range(0, 1) == 1;
      pc  = (r & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      tgt = $urandom();
      rp  = (($urandom()) & 32'hFFFF_FF00) | (32'($urandom_range(0, 9)) << 2);
      @(negedge clk);
      upd_valid = v; upd_pc = pc; upd_taken = t; upd_predicted = p; upd_target = tgt;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      model_step(v, pc, t, p, tgt);
      rd_pc = rp;
      #1;
      check($sformatf("rand%0d_pb", n), 32'(predictionbuffer), m_tbl[idx_of(rp)]);
      check($sformatf("rand%0d_mispredict", n), 32'(mispredict), 32'(m_mis));
      check($sformatf("rand%0d_redirect", n), redirect_pc, m_red);
      check($sformatf("rand%0d_branch_count", n), 32'(branch_count), m_bc);
      check($sformatf("rand%0d_mispredict_count", n), 32'(mispredict_count), m_mc);
      $display("rand%0d: v=%0b pc=%08h t=%0b p=%0b rd=%08h pb=%0d mis=%0b red=%08h bc=%0d mc=%0d",
               n, v, pc, t, p, rp, predictionbuffer, mispredict, redirect_pc,
               branch_count, mispredict_count);
    end

    // Statistics saturation after 65535 mispredicts.
    do_reset();
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_predicted = 1'b0; upd_target = 32'h20;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_bc_fffe", 32'(branch_count), 32'hFFFE);
    check("sat_mc_fffe", 32'(mispredict_count), 32'hFFFE);
    @(posedge clk);
    #1;
    check("sat_bc_ffff", 32'(branch_count), 32'hFFFF);
    check("sat_mc_ffff", 32'(mispredict_count), 32'hFFFF);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    check("sat_bc_hold", 32'(branch_count), 32'hFFFF);
    check("sat_mc_hold", 32'(mispredict_count), 32'hFFFF);
    check("sat_mispredict", 32'(mispredict), 32'h1);
    $display("saturation: bc=%04h mc=%04h", branch_count, mispredict_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
